interp_operand_sequencer: RTL
=============================

INTERP_OPERAND_SEQUENCER -- requirements
Module: interp_operand_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, lane operand width matching the vector ALU lane.
REQ-002 SHALL have parameter LEN_W, default 10, width of the row-length field.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to process one row; honoured only in IDLE.
REQ-006 SHALL have port row_len  input  LEN_W  pixel count of the row, sampled when start is honoured.
REQ-007 SHALL have port cfg_vcsub  input  1  VCSub mode, sampled when start is honoured.
REQ-008 SHALL have ports in_valid input 1, in_data input DATA_W, in_ready output 1  pixel stream; a transfer occurs when in_valid and in_ready are both high.
REQ-009 SHALL have ports out_valid output 1, out_ready input 1  ALU issue handshake; an issue occurs when out_valid and out_ready are both high.
REQ-010 SHALL have ports out_alu_op output 3, out_vcsub output 1, out_a output DATA_W, out_b output DATA_W, out_last output 1  issue payload to the vector ALU.
REQ-011 SHALL have ports busy output 1 (state not IDLE) and done output 1 (one-cycle row-complete pulse).

Function
REQ-012 SHALL implement FSM states IDLE, FETCH0, COPY, FETCHN, FWD, BWD, DONE.
REQ-013 IDLE + start: row_len==0 -> DONE; otherwise latch rem=row_len-1, latch cfg_vcsub, -> FETCH0; start in any other state SHALL be ignored.
REQ-014 FETCH0/FETCHN SHALL drive in_ready=1 (0 elsewhere); FETCH0 transfer -> cur<=in_data, -> COPY; FETCHN transfer -> nxt<=in_data, rem<=rem-1, -> FWD.
REQ-015 COPY SHALL issue op 3'b000, a=cur, b=cur, out_last=(rem==0); on issue, rem==0 -> DONE, else -> FETCHN.
REQ-016 FWD SHALL issue op 3'b100, a=cur, b=nxt; on issue -> BWD.
REQ-017 BWD SHALL issue op 3'b100, a=nxt, b=cur; on issue cur<=nxt, -> COPY.
REQ-018 out_valid SHALL be 1 exactly in COPY/FWD/BWD; payload SHALL remain stable while out_valid && !out_ready.
REQ-019 out_vcsub SHALL equal the latched cfg_vcsub on every issue.
REQ-020 out_last SHALL be 0 except on the final COPY of a row.
REQ-021 A row of N>=1 pixels SHALL yield exactly 3N-2 issues and consume exactly N pixels; no pixel SHALL be fetched beyond N.
REQ-022 DONE SHALL assert done for exactly one cycle, then -> IDLE; busy SHALL be 0 only in IDLE.
REQ-023 Back-pressure: any number of out_ready-low cycles SHALL stall the FSM without losing or duplicating issues; in_valid-low likewise stalls FETCH states.
REQ-024 Throughput with out_ready and in_valid held high SHALL be 4 cycles per interior pixel (1 fetch + 3 issues).
REQ-025 rem SHALL never wrap below zero; row_len = 2^LEN_W-1 SHALL be processed correctly.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, cur=nxt=rem=0, latched vcsub=0.
REQ-027 During reset all outputs SHALL be 0 (in_ready, out_valid, out_alu_op, out_vcsub, out_a, out_b, out_last, busy, done).
REQ-028 Reset asserted mid-row SHALL abandon the row; no further issue or done SHALL occur until a new start.

Structure
REQ-029 ALU opcode constants OP_COPY=3'b000 and OP_BILINEAR=3'b100 and the FSM state enum SHALL reside in shared package interp_pkg.
REQ-030 SHALL be a single module with no sub-modules; state, cur, nxt, rem, latched vcsub are its only registers.

Verification
REQ-031 row_len=3, pixels 0,30,60, out_ready=1 -> issues (op,a,b): (0,0,0),(4,0,30),(4,30,0),(0,30,30),(4,30,60),(4,60,30),(0,60,60,last=1); then done pulse; downstream ALU results 0,10,20,30,40,50,60.
REQ-032 row_len=1, pixel 99 -> single issue (0,99,99,last=1), done next cycle, in_ready never high again.
REQ-033 row_len=0 -> no in_ready, no out_valid, done pulses within 2 cycles of start.
REQ-034 row_len=3 with out_ready toggling 1-of-3 cycles and in_valid random -> same 7-issue sequence as REQ-031, payload stable during stalls.
REQ-035 rst_n pulsed low during FWD of row_len=4 -> all outputs 0 immediately; new start with row_len=2 pixels 3,6 -> (0,3,3),(4,3,6),(4,6,3),(0,6,6,last=1).
REQ-036 start asserted while busy with different row_len/cfg_vcsub -> ignored; out_vcsub keeps originally latched value through row end.

Source files
------------

// File: rtl/interp_pkg.sv
// Shared definitions for the interpolation operand sequencer:
// ALU opcodes, FSM state encoding and small decode helpers.
package interp_pkg;

  // Vector ALU opcodes used by the sequencer.
  localparam logic [2:0] OP_COPY     = 3'b000;
  localparam logic [2:0] OP_BILINEAR = 3'b100;

  // Row-processing FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH0 = 3'd1,
    ST_COPY   = 3'd2,
    ST_FETCHN = 3'd3,
    ST_FWD    = 3'd4,
    ST_BWD    = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  // States in which an operand pair is offered to the ALU.
  function automatic logic is_issue_state(input state_e s);
    return (s == ST_COPY) || (s == ST_FWD) || (s == ST_BWD);
  endfunction

  // States in which a pixel is accepted from the input stream.
  function automatic logic is_fetch_state(input state_e s);
    return (s == ST_FETCH0) || (s == ST_FETCHN);
  endfunction

endpackage

// File: rtl/interp_operand_sequencer.sv
// Interpolation operand sequencer: walks a row of pixels and issues
// COPY / BILINEAR operand pairs to the vector ALU. For N pixels it
// fetches exactly N pixels and issues 3N-2 operations.
module interp_operand_sequencer
  import interp_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  row_len,
  input  logic              cfg_vcsub,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_alu_op,
  output logic              out_vcsub,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  cur_q, cur_d;
  logic [DATA_W-1:0]  nxt_q, nxt_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               vcsub_q, vcsub_d;

  logic               rem_zero;

  assign rem_zero = (rem_q == '0);

  // Next-state and datapath update; rem counts pixels still to fetch.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    rem_d   = rem_q;
    vcsub_d = vcsub_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (row_len == '0) begin
            state_d = ST_DONE;
          end else begin
            rem_d   = row_len - LEN_W'(1);
            vcsub_d = cfg_vcsub;
            state_d = ST_FETCH0;
          end
        end
      end

      ST_FETCH0: begin
        if (in_valid) begin
          cur_d   = in_data;
          state_d = ST_COPY;
        end
      end

      ST_COPY: begin
        if (out_ready) begin
          state_d = rem_zero ? ST_DONE : ST_FETCHN;
        end
      end

      // Only reachable with rem != 0, so the decrement cannot wrap.
      ST_FETCHN: begin
        if (in_valid) begin
          nxt_d   = in_data;
          rem_d   = rem_q - LEN_W'(1);
          state_d = ST_FWD;
        end
      end

      ST_FWD: begin
        if (out_ready) begin
          state_d = ST_BWD;
        end
      end

      ST_BWD: begin
        if (out_ready) begin
          cur_d   = nxt_q;
          state_d = ST_COPY;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and operand registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      nxt_q   <= '0;
      rem_q   <= '0;
      vcsub_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      rem_q   <= rem_d;
      vcsub_q <= vcsub_d;
    end
  end

  // Output decode purely from registered state, so payload is stable
  // for as long as the FSM waits on out_ready.
  always_comb begin
    in_ready   = is_fetch_state(state_q);
    out_valid  = is_issue_state(state_q);
    out_alu_op = OP_COPY;
    out_a      = '0;
    out_b      = '0;
    out_last   = 1'b0;
    out_vcsub  = 1'b0;
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_DONE);

    unique case (state_q)
      ST_COPY: begin
        out_alu_op = OP_COPY;
        out_a      = cur_q;
        out_b      = cur_q;
        out_last   = rem_zero;
        out_vcsub  = vcsub_q;
      end
      ST_FWD: begin
        out_alu_op = OP_BILINEAR;
        out_a      = cur_q;
        out_b      = nxt_q;
        out_vcsub  = vcsub_q;
      end
      ST_BWD: begin
        out_alu_op = OP_BILINEAR;
        out_a      = nxt_q;
        out_b      = cur_q;
        out_vcsub  = vcsub_q;
      end
      default: begin
        out_alu_op = OP_COPY;
      end
    endcase
  end

endmodule
